// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for an unsigned iterative mult/div unit; handles sign conditioning and result fixup.
// Optional MULDIV_DIVZERO_BYPASS_EN: divide-by-zero responds directly without starting the unit.
module muldiv_arbiter #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    output logic        md_valid,
    output logic        md_mode,
    output logic [31:0] md_in_a,
    output logic [31:0] md_in_b,
    input  logic        md_ready,
    input  logic [63:0] md_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t      state_q, state_d;
    logic        prio_q, owner_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, res_q;
    logic        sa_q, sb_q;

    logic        sel, grant;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic        in_sa, in_sb;

    logic        mneg;
    logic [63:0] prod;
    logic [31:0] quo, rem, fix;

    // Selection: sole valid requester, or the priority holder on contention.
    always_comb begin
        sel   = (req0_valid & req1_valid) ? prio_q : req1_valid;
        grant = (state_q == IDLE) & (req0_valid | req1_valid) & rst_n;
        in_op = sel ? req1_op : req0_op;
        in_a  = sel ? req1_a  : req0_a;
        in_b  = sel ? req1_b  : req0_b;
        in_sa = in_a[31] & ((in_op == OP_MULH) | (in_op == OP_MULHSU) |
                            (in_op == OP_DIV)  | (in_op == OP_REM));
        in_sb = in_b[31] & ((in_op == OP_MULH) | (in_op == OP_DIV) | (in_op == OP_REM));
    end

    assign req0_ready = grant & ~sel;
    assign req1_ready = grant & sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant) begin
`ifdef MULDIV_DIVZERO_BYPASS_EN
                state_d = (in_op[2] && in_b == '0) ? RESP : ISSUE;
`else
                state_d = ISSUE;
`endif
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (md_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Signed fixup of the unsigned unit result; overflow case falls out naturally (|b|=1, signs cancel).
    always_comb begin
        mneg = ((op_q == OP_MULH) & (sa_q ^ sb_q)) | ((op_q == OP_MULHSU) & sa_q);
        prod = mneg ? -md_out : md_out;
        quo  = md_out[31:0];
        rem  = md_out[63:32];
        fix  = '0;
        case (op_q)
            OP_MUL:                        fix = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix = prod[63:32];
            OP_DIV:                        fix = (sa_q ^ sb_q) ? -quo : quo;
            OP_DIVU:                       fix = quo;
            OP_REM:                        fix = sa_q ? -rem : rem;
            default:                       fix = rem;
        endcase
        if (op_q[2] && b_q == '0) fix = op_q[1] ? a_q : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q  <= (RR_INIT != 0);
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            md_in_a <= '0;
            md_in_b <= '0;
            res_q   <= '0;
        end else begin
            if (grant) begin
                owner_q <= sel;
                op_q    <= in_op;
                a_q     <= in_a;
                b_q     <= in_b;
                sa_q    <= in_sa;
                sb_q    <= in_sb;
                md_in_a <= in_sa ? -in_a : in_a;
                md_in_b <= in_sb ? -in_b : in_b;
`ifdef MULDIV_DIVZERO_BYPASS_EN
                if (in_op[2] && in_b == '0) res_q <= in_op[1] ? in_a : '1;
`endif
            end
            if (state_q == WAIT && md_ready) res_q <= fix;
            if (state_q == RESP) prio_q <= ~owner_q;
        end
    end

    assign md_valid    = (state_q == ISSUE);
    assign md_mode     = op_q[2];
    assign rsp0_valid  = (state_q == RESP) & ~owner_q;
    assign rsp1_valid  = (state_q == RESP) & owner_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter: behavioural arithmetic/arbitration model plus a bench-side mult/div unit.
module tb_muldiv_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        md_valid, md_mode, md_ready;
    logic [31:0] md_in_a, md_in_b;
    logic [63:0] md_out;

    int tests = 0, fails = 0;

    muldiv_arbiter #(.RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .md_valid(md_valid), .md_mode(md_mode), .md_in_a(md_in_a), .md_in_b(md_in_b),
        .md_ready(md_ready), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the ISA definitions.
    function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      as_l, bs_l, au_l, bu_l;
        logic [63:0] p;
        int          ia, ib;
        as_l = longint'($signed(a)); bs_l = longint'($signed(b));
        au_l = longint'({32'b0, a}); bu_l = longint'({32'b0, b});
        ia = $signed(a); ib = $signed(b);
        p = '0;
        case (op)
            3'd0: begin p = au_l * bu_l; return p[31:0]; end
            3'd1: begin p = as_l * bs_l; return p[63:32]; end
            3'd2: begin p = as_l * bu_l; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                  else return ia / ib;
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                  else return ia % ib;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Bench-side iterative unit: fixed 3-cycle latency, garbage on divide-by-zero.
    logic [31:0] u_a, u_b;
    logic        u_mode, u_rdy, spur;
    int          u_cnt;
    assign md_ready = u_rdy | spur;
    always @(posedge clk) begin
        if (!rst_n) begin
            u_cnt <= 0; u_rdy <= 1'b0; md_out <= '0;
        end else begin
            u_rdy <= 1'b0;
            if (md_valid) begin
                u_a <= md_in_a; u_b <= md_in_b; u_mode <= md_mode; u_cnt <= 3;
            end else if (u_cnt != 0) begin
                u_cnt <= u_cnt - 1;
                if (u_cnt == 1) begin
                    u_rdy <= 1'b1;
                    if (!u_mode)       md_out <= {32'b0, u_a} * {32'b0, u_b};
                    else if (u_b == 0) md_out <= 64'hDEADBEEF_CAFEF00D;
                    else               md_out <= {u_a % u_b, u_a / u_b};
                end
            end
        end
    end
    always @(negedge clk) if (rst_n && u_cnt != 0) begin
        chk("md_in_a_stable", md_in_a, u_a);
        chk("md_in_b_stable", md_in_b, u_b);
        chk("md_mode_stable", md_mode, u_mode);
    end

    // Transaction-level model: arbitration, expected result, conditioned operands.
    bit          busy = 0, prio_m = 0, owner_m = 0, need_issue = 0, issued = 0;
    bit          exp_r0, exp_r1;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, exp_res, exp_ca, exp_cb;
    int          wait_cyc = 0, mdv_total = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0; prio_m = 0; issued = 0;
        end else begin
            exp_r0 = 0; exp_r1 = 0;
            if (!busy) begin
                if (req0_valid && req1_valid) begin exp_r0 = !prio_m; exp_r1 = prio_m; end
                else begin exp_r0 = req0_valid; exp_r1 = req1_valid; end
            end
            chk("req0_ready", req0_ready, exp_r0);
            chk("req1_ready", req1_ready, exp_r1);
            chk("md_valid_allowed", md_valid && !(busy && need_issue && !issued), 0);
            if (md_valid) begin
                mdv_total++;
                if (busy && need_issue && !issued) begin
                    chk("md_in_a", md_in_a, exp_ca);
                    chk("md_in_b", md_in_b, exp_cb);
                    chk("md_mode", md_mode, m_op[2]);
                    issued = 1;
                end
            end
            chk("rsp_allowed", (rsp0_valid | rsp1_valid) && !busy, 0);
            if (busy && (rsp0_valid || rsp1_valid)) begin
                chk("rsp_owner", {rsp1_valid, rsp0_valid}, owner_m ? 2'b10 : 2'b01);
                chk("rsp_result", owner_m ? rsp1_result : rsp0_result, exp_res);
                if (need_issue) chk("md_issued", issued, 1);
                busy = 0; prio_m = !owner_m;
            end else if (busy) begin
                wait_cyc++;
                if (wait_cyc > 60) begin chk("rsp_timeout", busy, 0); busy = 0; end
            end
            if (exp_r0 || exp_r1) begin
                m_op = exp_r1 ? req1_op : req0_op;
                m_a  = exp_r1 ? req1_a  : req0_a;
                m_b  = exp_r1 ? req1_b  : req0_b;
                busy = 1; owner_m = exp_r1; issued = 0; wait_cyc = 0;
                exp_res = ref_fn(m_op, m_a, m_b);
                exp_ca = ((m_op == 1 || m_op == 2 || m_op == 4 || m_op == 6) && m_a[31]) ? -m_a : m_a;
                exp_cb = ((m_op == 1 || m_op == 4 || m_op == 6) && m_b[31]) ? -m_b : m_b;
                need_issue = 1;
`ifdef MULDIV_DIVZERO_BYPASS_EN
                if (m_op[2] && m_b == 0) need_issue = 0;
`endif
            end
        end
    end

    task automatic set_req(input int id, input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
        else         begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk("wait_idle", ok, 1);
    endtask

    task automatic do_op(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        bit got = 0;
        @(posedge clk); #1;
        set_req(id, 1, op, a, b);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin got = 1; break; end
        end
        chk({name, "_accept"}, got, 1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 0; else req1_valid = 0;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ((id == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1;
                chk(name, (id == 0) ? rsp0_result : rsp1_result, exp);
                break;
            end
        end
        chk({name, "_rsp"}, got, 1);
    endtask

    task automatic both(input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int exp_first, input string name);
        int first = -1, n = 0;
        bit d0, d1;
        @(posedge clk); #1;
        set_req(0, 1, op0, a0, b0);
        set_req(1, 1, op1, a1, b1);
        for (int c = 0; c < 200 && n < 2; c++) begin
            @(negedge clk);
            d0 = req0_ready; d1 = req1_ready;
            if (d0) begin if (first < 0) first = 0; n++; end
            if (d1) begin if (first < 0) first = 1; n++; end
            @(posedge clk); #1;
            if (d0) req0_valid = 0;
            if (d1) req1_valid = 0;
        end
        chk({name, "_first"}, first, exp_first);
        chk({name, "_served"}, n, 2);
        req0_valid = 0; req1_valid = 0;
        wait_idle();
    endtask

    initial begin
        int mdv0;
        bit got;
        spur = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_md_valid", md_valid, 0);
        chk("rst_md_in_a", md_in_a, 0);
        chk("rst_md_in_b", md_in_b, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp_result", rsp0_result, 0);

        both(3'd0, 32'd3, 32'd4, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "both_rr0");
        do_op(0, 3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, "mulh_neg");
        chk("mulh_md_in_a", u_a, 32'd2);
        chk("mulh_md_in_b", u_b, 32'd3);
        both(3'd5, 32'd100, 32'd7, 3'd2, 32'hFFFFFFFF, 32'd2, 1, "both_rr1");
        do_op(1, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
        do_op(1, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
        both(3'd6, 32'd7, 32'hFFFFFFFE, 3'd0, 32'd6, 32'd7, 0, "both_rr2");

        do_op(0, 3'd0, 32'd6, 32'd7, 32'd42, "mul");
        do_op(1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        do_op(0, 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
        do_op(1, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
        do_op(0, 3'd5, 32'd100, 32'd7, 32'd14, "divu");
        do_op(0, 3'd7, 32'd100, 32'd7, 32'd2, "remu");
        do_op(1, 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_negb");
        do_op(1, 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, "rem_negb");

        mdv0 = mdv_total;
        do_op(0, 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_zero");
`ifdef MULDIV_DIVZERO_BYPASS_EN
        chk("divzero_md_valid", mdv_total - mdv0, 0);
`else
        chk("divzero_md_valid", mdv_total - mdv0, 1);
`endif
        do_op(0, 3'd7, 32'd5, 32'd0, 32'd5, "remu_zero");
        do_op(1, 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_zero");
        do_op(1, 3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_zero");
        do_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        do_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");

        // Stray completion pulse while idle must not produce a response.
        @(posedge clk); #1 spur = 1;
        @(posedge clk); #1 spur = 0;
        repeat (4) @(posedge clk);

        // Reset during WAIT: operation abandoned, block idle right after.
        #1 set_req(0, 1, 3'd5, 32'd100, 32'd7);
        got = 0;
        for (int c = 0; c < 20; c++) begin @(negedge clk); if (req0_ready) begin got = 1; break; end end
        chk("rst_op_accept", got, 1);
        @(posedge clk); #1 req0_valid = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin @(negedge clk); if (md_valid) begin got = 1; break; end end
        chk("rst_op_issue", got, 1);
        @(posedge clk); #1 rst_n = 0;
        set_req(0, 1, 3'd0, 32'd6, 32'd7);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", req0_ready, 1);
        chk("post_rst_md_in_a", md_in_a, 0);
        chk("post_rst_result", rsp0_result, 0);
        chk("post_rst_rsp", rsp0_valid, 0);
        @(posedge clk); #1 req0_valid = 0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp0_valid) begin got = 1; chk("post_rst_mul", rsp0_result, 32'd42); break; end
        end
        chk("post_rst_mul_rsp", got, 1);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
